// File: rtl/prog_rom.sv
// -----------------------------------------------------------------------------
// prog_rom -- run-time loadable program memory for the RV32 subset core.
//
// The program image arrives as a byte-serial valid/ready stream (boot loader or
// bench UART bridge). Bytes are assembled little-endian into words and written
// sequentially from word 0. Once the requested number of words is in, the block
// enters RUN and serves fetches through a registered, 1-cycle-latency read port
// with alignment and range checking.
//
// Handshake: a byte transfers on a rising clock edge where load_valid and
// load_ready are both high. load_ready is high only in LOAD, independent of
// load_valid. The producer may hold or withdraw load_valid freely.
//
// Parameters:
//   WIDTH     instruction / address width, multiple of 8
//   DEPTH     number of words, power of two
//   NOP_WORD  word returned on a faulted read (addi x0,x0,0)
//   ABITS     word-index width, $clog2(DEPTH)
//
// Ports:
//   clock, nreset          rising-edge clock, asynchronous active-low reset
//   load_start             one-cycle pulse; begins a load (ignored in LOAD)
//   load_length[ABITS:0]   words to load, sampled with load_start, clamped to DEPTH
//   load_valid, load_data  program byte stream
//   load_ready             byte accepted this cycle when load_valid is high
//   load_done              high while in RUN
//   read_en, address       fetch request (byte address), honoured only in RUN
//   rdata, rdata_valid     fetch result, one cycle after read_en
//   fault                  with rdata_valid: misaligned or out-of-range fetch
//   parity_error           (PROG_ROM_PARITY_EN only) stored parity mismatch
//   fsm_state              debug view of the load/run state machine
//
// Optional feature: define PROG_ROM_PARITY_EN to store an even-parity bit per
// word and report mismatches on non-faulted reads through parity_error.
// -----------------------------------------------------------------------------
module prog_rom #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2048,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(32'h00000013),
    localparam int              ABITS    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             load_start,
    input  logic [ABITS:0]   load_length,
    input  logic             load_valid,
    input  logic [7:0]       load_data,
    output logic             load_ready,
    output logic             load_done,
    input  logic             read_en,
    input  logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_valid,
    output logic             fault,
`ifdef PROG_ROM_PARITY_EN
    output logic             parity_error,
`endif
    output logic [1:0]       fsm_state
);

    localparam int BYTES = WIDTH / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ABITS:0]   LEN_MAX  = (ABITS + 1)'(DEPTH);
    localparam logic [ABITS:0]   LEN_ONE  = (ABITS + 1)'(1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BYTES - 1);
    localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [BC_W-1:0]  byte_cnt;
    logic [ABITS:0]   word_idx;
    logic [ABITS:0]   len_reg;
    logic [WIDTH-1:0] word_buf;
    logic [WIDTH-1:0] wr_word;

    logic [WIDTH-1:0] mem [DEPTH];
`ifdef PROG_ROM_PARITY_EN
    logic             par_mem [DEPTH];
`endif

    // ------------------------------------------------------------------
    // Load-side decode
    // ------------------------------------------------------------------
    logic           byte_fire;
    logic           last_byte;
    logic           word_fire;
    logic           last_word;
    logic           start_ok;
    logic [ABITS:0] len_clamp;

    assign byte_fire = load_valid && load_ready;
    assign last_byte = (byte_cnt == BC_LAST);
    assign word_fire = byte_fire && last_byte;
    // len_reg is never zero while in LOAD, so len_reg-1 does not wrap there.
    assign last_word = (word_idx == (len_reg - LEN_ONE));
    // load_start is only honoured outside LOAD.
    assign start_ok  = load_start && (state != ST_LOAD);
    assign len_clamp = (load_length > LEN_MAX) ? LEN_MAX : load_length;

    // Word being assembled with the current byte dropped into its lane; this
    // is also the value written to memory when the final byte lands.
    always_comb begin
        wr_word = word_buf;
        wr_word[{byte_cnt, 3'b000} +: 8] = load_data;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    next_state = (len_clamp == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Leaving on the edge that writes the last word drops
                // load_ready in the same cycle as that write.
                if (word_fire && last_word) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        load_ready = 1'b0;
        load_done  = 1'b0;
        fsm_state  = state;
        case (state)
            ST_LOAD: load_ready = 1'b1;
            ST_RUN:  load_done  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load counters and byte assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            byte_cnt <= '0;
            word_idx <= '0;
            len_reg  <= '0;
            word_buf <= '0;
        end else if (start_ok) begin
            byte_cnt <= '0;
            word_idx <= '0;
            len_reg  <= len_clamp;
            word_buf <= '0;
        end else if (byte_fire) begin
            word_buf <= wr_word;
            if (last_byte) begin
                byte_cnt <= '0;
                word_idx <= word_idx + LEN_ONE;
            end else begin
                byte_cnt <= byte_cnt + BC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Program memory write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (word_fire) begin
            mem[word_idx[ABITS-1:0]] <= wr_word;
`ifdef PROG_ROM_PARITY_EN
            // Even parity: stored bit makes the total count of ones even.
            par_mem[word_idx[ABITS-1:0]] <= ^wr_word;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------
    logic             rd_fire;
    logic             rd_misalign;
    logic             rd_range;
    logic             rd_fault;
    logic [ABITS-1:0] rd_idx;

    assign rd_fire     = read_en && (state == ST_RUN);
    assign rd_misalign = (address[1:0] != 2'b00);
    // Full word address is range-checked; only the low ABITS index the array.
    assign rd_range    = ((address >> 2) >= DEPTH_W);
    assign rd_fault    = rd_misalign || rd_range;
    assign rd_idx      = address[ABITS+1:2];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
        end else if (rd_fire) begin
            rdata_valid <= 1'b1;
            fault       <= rd_fault;
            rdata       <= rd_fault ? NOP_WORD : mem[rd_idx];
        end else begin
            // rdata deliberately holds its last value between fetches.
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
        end
    end

`ifdef PROG_ROM_PARITY_EN
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            parity_error <= 1'b0;
        end else if (rd_fire && !rd_fault) begin
            parity_error <= ((^mem[rd_idx]) != par_mem[rd_idx]);
        end else begin
            parity_error <= 1'b0;
        end
    end
`endif

endmodule
